// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port arbiter for the shadow screen VRAM (pages 5 and 7).
// ULA fetches always win the port; snooped CPU screen writes are queued in a
// small in-order FIFO and drained whenever the ULA leaves a cycle idle. ULA
// reads that hit a queued write take the newest queued data instead of VRAM.
module vram_arbiter #(
    parameter int DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        nRESET,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        m128,
    input  logic [2:0]  page_ram,
    input  logic        ula_rd,
    input  logic [14:0] ula_addr,
    output logic [7:0]  ula_dout,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

    // Queue storage and control state.
    wr_entry_t          fifo_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               overflow_q, overflow_d;

    // Port-side holding registers and the forwarding pipeline stage.
    logic [14:0]        ram_addr_q;
    logic [7:0]         ram_din_q;
    logic               rd_valid_q;
    logic               hit_q, hit_d;
    logic [7:0]         fwd_q, fwd_d;

    // Decode and grant signals.
    logic               dec_hit;
    logic [14:0]        dec_addr;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               is_full;
    wr_entry_t          head;

    // Decode the CPU write address into a VRAM address when it targets a screen page.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        dec_hit  = 1'b0;
        dec_addr = {1'b0, cpu_addr[13:0]};
        if (cpu_addr[15:14] == 2'b01) begin
            dec_hit = 1'b1;
        end else if (m128 && cpu_addr[15:14] == 2'b11) begin
            if (page_ram == 3'd5) begin
                dec_hit = 1'b1;
            end else if (page_ram == 3'd7) begin
                dec_hit  = 1'b1;
                dec_addr = {1'b1, cpu_addr[13:0]};
            end
        end
    end

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign push_req = cpu_wr && dec_hit;
    // A pop only happens on an idle ULA cycle with an entry present at cycle start.
    assign pop      = !ula_rd && (count_q != '0);
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign push_ok  = push_req && (!is_full || pop);
    assign head     = fifo_mem[rd_ptr_q];

    // Compute pointer, count, full and sticky overflow next-state values.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Search entries valid at cycle start, oldest to newest, so the newest match wins.
    always_comb begin
        hit_d = 1'b0;
        fwd_d = 8'h00;
        if (ula_rd) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) < count_q &&
                    fifo_mem[rd_ptr_q + PTR_W'(i)].addr == ula_addr) begin
                    hit_d = 1'b1;
                    fwd_d = fifo_mem[rd_ptr_q + PTR_W'(i)].data;
                end
            end
        end
    end

    // Grant the VRAM port: ULA first, then the FIFO head, otherwise hold the address.
    always_comb begin
        ram_addr = ram_addr_q;
        ram_din  = ram_din_q;
        if (ula_rd) begin
            ram_addr = ula_addr;
        end else if (pop) begin
            ram_addr = head.addr;
            ram_din  = head.data;
        end
    end

    // Suppress the write strobe while reset is asserted so no partial write escapes.
    assign ram_we    = nRESET && pop;
    assign ula_dout  = rd_valid_q ? (hit_q ? fwd_q : ram_dout) : 8'h00;
    assign fifo_full = full_q;
    assign overflow  = overflow_q;

    // Write accepted entries into the queue storage.
    always_ff @(posedge clk_sys) begin
        // NOTE: the storage array is deliberately not reset; validity comes from count_q alone.
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= '{addr: dec_addr, data: cpu_din};
        end
    end

    // Register control state, port holding values and the read pipeline with synchronous reset.
    always_ff @(posedge clk_sys) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!nRESET) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            fwd_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            ram_addr_q <= ram_addr;
            ram_din_q  <= ram_din;
            rd_valid_q <= ula_rd;
            hit_q      <= hit_d;
            fwd_q      <= fwd_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed-vector bench for vram_arbiter with a behavioural
// single-port VRAM (1-cycle registered read, read-before-write).
module tb_vram_arbiter;

    logic        clk_sys = 1'b0;
    logic        nRESET;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        m128;
    logic [2:0]  page_ram;
    logic        ula_rd;
    logic [14:0] ula_addr;
    logic [7:0]  ula_dout;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic        fifo_full;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] vram [logic [14:0]];

    vram_arbiter #(.DEPTH(8)) dut (
        .clk_sys   (clk_sys),
        .nRESET    (nRESET),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .m128      (m128),
        .page_ram  (page_ram),
        .ula_rd    (ula_rd),
        .ula_addr  (ula_addr),
        .ula_dout  (ula_dout),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // VRAM model: read the old contents, then apply any write.
    always @(posedge clk_sys) begin
        ram_dout <= vram.exists(ram_addr) ? vram[ram_addr] : 8'h00;
        if (ram_we) vram[ram_addr] = ram_din;
    end

    function automatic logic [7:0] peek(input logic [14:0] a);
        return vram.exists(a) ? vram[a] : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        tick();
        cpu_wr   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRESET = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
        m128 = 1'b0; page_ram = '0; ula_rd = 1'b0; ula_addr = '0;

        // Reset state
        tick(); tick();
        #1;
        check("rst ula_dout", ula_dout, 8'h00);
        check("rst ram_we", ram_we, 1'b0);
        check("rst ram_addr", ram_addr, 15'h0000);
        check("rst ram_din", ram_din, 8'h00);
        check("rst fifo_full", fifo_full, 1'b0);
        check("rst overflow", overflow, 1'b0);

        // Basic drain of a page-5 write at 0x4000
        tick();
        nRESET = 1'b1;
        cpu_write(16'h4000, 8'hA5);
        #1;
        check("t1 ram_we", ram_we, 1'b1);
        check("t1 ram_addr", ram_addr, 15'h0000);
        check("t1 ram_din", ram_din, 8'hA5);
        tick(); #1;
        check("t1 empty we", ram_we, 1'b0);
        check("t1 vram", peek(15'h0000), 8'hA5);

        // Decode: page 7 at 0xC000, rejected pages/regions
        m128 = 1'b1; page_ram = 3'd7;
        cpu_write(16'hC123, 8'h3C);
        #1;
        check("p7 ram_we", ram_we, 1'b1);
        check("p7 ram_addr", ram_addr, 15'h4123);
        check("p7 ram_din", ram_din, 8'h3C);
        tick(); #1;
        check("p7 idle we", ram_we, 1'b0);
        check("p7 addr hold", ram_addr, 15'h4123);
        page_ram = 3'd3;
        cpu_write(16'hC123, 8'h55);
        #1;
        check("p3 no push", ram_we, 1'b0);
        cpu_write(16'h8000, 8'h66);
        #1;
        check("8000 no push", ram_we, 1'b0);
        page_ram = 3'd5;
        cpu_write(16'hC200, 8'h77);
        #1;
        check("p5 ram_we", ram_we, 1'b1);
        check("p5 ram_addr", ram_addr, 15'h0200);
        m128 = 1'b0; page_ram = 3'd7;
        cpu_write(16'hC300, 8'h88);
        #1;
        check("m48 no push", ram_we, 1'b0);
        tick(); #1;
        check("vram 4123", peek(15'h4123), 8'h3C);
        check("vram 0200", peek(15'h0200), 8'h77);

        // Forwarding: two writes to 0x4010 while the ULA reads 0x0010
        ula_rd = 1'b1; ula_addr = 15'h0010;
        cpu_wr = 1'b1; cpu_addr = 16'h4010; cpu_din = 8'h11;
        tick();
        cpu_din = 8'h22;
        #1;
        check("fwd same-cycle old", ula_dout, 8'h00);
        check("fwd no write", ram_we, 1'b0);
        tick();
        cpu_wr = 1'b0;
        #1;
        check("fwd first", ula_dout, 8'h11);
        tick();
        ula_rd = 1'b0;
        #1;
        check("fwd newest", ula_dout, 8'h22);
        check("ord1 we", ram_we, 1'b1);
        check("ord1 addr", ram_addr, 15'h0010);
        check("ord1 din", ram_din, 8'h11);
        tick(); #1;
        check("ula_dout idle", ula_dout, 8'h00);
        check("ord2 we", ram_we, 1'b1);
        check("ord2 din", ram_din, 8'h22);
        tick(); #1;
        check("ord done we", ram_we, 1'b0);
        check("ord vram", peek(15'h0010), 8'h22);
        ula_rd = 1'b1; ula_addr = 15'h0010;
        tick();
        ula_rd = 1'b0;
        #1;
        check("ram read back", ula_dout, 8'h22);

        // Fill to full under continuous ULA reads; ninth write dropped
        ula_rd = 1'b1; ula_addr = 15'h1000;
        for (int i = 0; i < 9; i++) begin
            cpu_write(16'h4100 + 16'(i), 8'h80 + 8'(i));
            #1;
            check($sformatf("fill%0d full", i), fifo_full, (i >= 7) ? 1'b1 : 1'b0);
            check($sformatf("fill%0d ovf", i), overflow, (i == 8) ? 1'b1 : 1'b0);
        end
        ula_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("drain%0d we", i), ram_we, 1'b1);
            check($sformatf("drain%0d addr", i), ram_addr, 15'h0100 + 15'(i));
            check($sformatf("drain%0d din", i), ram_din, 8'h80 + 8'(i));
            if (i >= 1) check($sformatf("drain%0d full", i), fifo_full, 1'b0);
            tick();
        end
        #1;
        check("drain done we", ram_we, 1'b0);
        check("drain full", fifo_full, 1'b0);
        check("ovf sticky", overflow, 1'b1);
        check("vram 0107", peek(15'h0107), 8'h87);
        check("vram 0108 dropped", peek(15'h0108), 8'h00);

        // Push into a full FIFO in the same cycle as a pop
        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        #1;
        check("ovf cleared", overflow, 1'b0);
        ula_rd = 1'b1; ula_addr = 15'h1000;
        for (int i = 0; i < 8; i++) cpu_write(16'h4200 + 16'(i), 8'h40 + 8'(i));
        #1;
        check("full8", fifo_full, 1'b1);
        ula_rd = 1'b0;
        cpu_wr = 1'b1; cpu_addr = 16'h4300; cpu_din = 8'h99;
        #1;
        check("pp pop addr", ram_addr, 15'h0200);
        check("pp pop we", ram_we, 1'b1);
        tick();
        cpu_wr = 1'b0;
        #1;
        check("pp still full", fifo_full, 1'b1);
        check("pp no ovf", overflow, 1'b0);
        for (int i = 1; i < 8; i++) begin
            #1;
            check($sformatf("pp%0d addr", i), ram_addr, 15'h0200 + 15'(i));
            check($sformatf("pp%0d din", i), ram_din, 8'h40 + 8'(i));
            tick();
        end
        #1;
        check("pp last addr", ram_addr, 15'h0300);
        check("pp last din", ram_din, 8'h99);
        tick(); #1;
        check("pp empty we", ram_we, 1'b0);

        // Reset with 5 entries queued discards them
        ula_rd = 1'b1; ula_addr = 15'h0400;
        for (int i = 0; i < 5; i++) cpu_write(16'h4400 + 16'(i), 8'h50 + 8'(i));
        nRESET = 1'b0; ula_rd = 1'b0;
        #1;
        check("rstq we in reset", ram_we, 1'b0);
        tick();
        nRESET = 1'b1;
        #1;
        check("rstq ula_dout", ula_dout, 8'h00);
        check("rstq overflow", overflow, 1'b0);
        check("rstq full", fifo_full, 1'b0);
        check("rstq ram_addr", ram_addr, 15'h0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rstq%0d we", i), ram_we, 1'b0);
            tick();
        end
        check("rstq vram 0400", peek(15'h0400), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
